// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch requester, data requester and memory-port signals
// shared between the arbiter (slave) and whoever drives the requests (master).
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DWIDTH-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_byte;
    logic [AWIDTH-1:0] dm_addr;
    logic [DWIDTH-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DWIDTH-1:0] dm_rdata;
    logic              mem_wr;
    logic [1:0]        mem_byte;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_dm;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_wr, mem_byte, mem_addr, mem_wdata, stall_if, stall_dm
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_wr, mem_byte, mem_addr, mem_wdata, stall_if, stall_dm
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between fetch and data,
// data first, with a bounded data run so a pending fetch is never starved.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} own_e;

    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    own_e       state_q, state_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       if_gnt, dm_gnt;

    always_comb begin
        dm_gnt    = bus.dm_req & ~(bus.if_req & (run_cnt_q == MAX_RUN));
        if_gnt    = bus.if_req & ~dm_gnt;
        run_cnt_d = (if_gnt | ~bus.if_req) ? 4'd0 :
                    (run_cnt_q == MAX_RUN) ? run_cnt_q : run_cnt_q + 4'd1;
        state_d   = if_gnt ? OWN_IF : dm_gnt ? OWN_DM : OWN_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OWN_NONE;
            run_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.stall_if  = bus.if_req & ~if_gnt;
    assign bus.stall_dm  = bus.dm_req & ~dm_gnt;
    // Idle cycles still present the fetch address so the port never floats.
    assign bus.mem_wr    = dm_gnt & bus.dm_we & ~rst;
    assign bus.mem_byte  = dm_gnt ? bus.dm_byte : 2'b00;
    assign bus.mem_addr  = AWIDTH'(dm_gnt ? bus.dm_addr : bus.if_addr);
    assign bus.mem_wdata = DWIDTH'(bus.dm_wdata);
    // Gating with rst drops a return whose grant landed on the edge reset arrived.
    assign bus.if_valid  = (state_q == OWN_IF) & ~rst;
    assign bus.dm_valid  = (state_q == OWN_DM) & ~rst;
    assign bus.if_rdata  = DWIDTH'(bus.mem_rdata);
    assign bus.dm_rdata  = DWIDTH'(bus.mem_rdata);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random requests checked against a
// transaction-level model of grants, memory contents and returns.
module tb_mem_port_arbiter;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_DATA_RUN(MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end

    int passed = 0;
    int total  = 0;
    int run    = 0;
    logic [31:0] mm [logic [31:0]];
    logic last_if, last_dm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [1:0] db, input logic [31:0] da, input logic [31:0] dd,
                        input logic rst_at_edge);
        logic eg_dm, eg_if;
        int own;
        logic [31:0] rd;
        @(negedge clk);
        bus.if_req = ir; bus.if_addr = ia;
        bus.dm_req = dr; bus.dm_we = dw; bus.dm_byte = db; bus.dm_addr = da; bus.dm_wdata = dd;
        #1;
        eg_dm = dr && !(ir && run >= MAX);
        eg_if = ir && !eg_dm;
        chk("dm_gnt", 32'(bus.dm_gnt), 32'(eg_dm));
        chk("if_gnt", 32'(bus.if_gnt), 32'(eg_if));
        chk("stall_if", 32'(bus.stall_if), 32'(ir && !eg_if));
        chk("stall_dm", 32'(bus.stall_dm), 32'(dr && !eg_dm));
        chk("mem_wr", 32'(bus.mem_wr), 32'(eg_dm && dw && !rst));
        if (eg_dm || eg_if) chk("mem_addr", bus.mem_addr, eg_dm ? da : ia);
        if (eg_dm) chk("mem_byte", 32'(bus.mem_byte), 32'(db));
        if (eg_if) chk("mem_byte_if", 32'(bus.mem_byte), 32'h0);
        last_if = eg_if; last_dm = eg_dm;
        own = eg_if ? 1 : eg_dm ? 2 : 0;
        rd  = eg_dm ? da : ia;
        rd  = mm.exists(rd) ? mm[rd] : 32'h0;
        if (eg_dm && dw && !rst) mm[da] = dd;
        run = (eg_if || !ir) ? 0 : (run < MAX ? run + 1 : run);
        @(posedge clk);
        if (rst_at_edge) rst = 1'b1;
        #1;
        if (rst) begin own = 0; run = 0; end
        chk("if_valid", 32'(bus.if_valid), 32'(own == 1));
        chk("dm_valid", 32'(bus.dm_valid), 32'(own == 2));
        if (own == 1) chk("if_rdata", bus.if_rdata, rd);
        if (own == 2 && !dw) chk("dm_rdata", bus.dm_rdata, rd);
    endtask

    initial begin
        string pat;
        logic ip, dp, w;
        logic [31:0] ia, da, dd;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[4] = 32'h00500093;
        mm[32'h10] = 32'h00500093;
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_byte = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        @(posedge clk); #1;
        chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_dm_valid", 32'(bus.dm_valid), 32'h0);
        chk("rst_run_cnt", 32'(dut.run_cnt_q), 32'h0);
        @(negedge clk); rst = 1'b0;
        step(1, 32'h10, 0, 0, 2'b00, 0, 0, 0);
        chk("fetch_data", bus.if_rdata, 32'h00500093);
        step(0, 0, 1, 1, 2'b10, 32'h20, 32'hDEADBEEF, 0);
        chk("write_ack", 32'(bus.dm_valid), 32'h1);
        step(0, 0, 1, 0, 2'b10, 32'h20, 0, 0);
        chk("read_back", bus.dm_rdata, 32'hDEADBEEF);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0);
        pat = "DDDDIDDDDI";
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h10, 1, 0, 2'b00, 32'h20, 0, 0);
            chk("pattern", 32'(last_dm), 32'(pat[i] == "D"));
            if (last_if) chk("run_clear", 32'(dut.run_cnt_q), 32'h0);
        end
        step(0, 0, 0, 0, 2'b00, 0, 0, 0);
        step(1, 32'h10, 0, 0, 2'b00, 0, 0, 0);
        step(0, 0, 1, 0, 2'b00, 32'h20, 0, 0);
        step(1, 32'h10, 0, 0, 2'b00, 0, 0, 0);
        step(0, 0, 1, 0, 2'b00, 32'h20, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0);
        step(1, 32'h10, 0, 0, 2'b00, 0, 0, 1);
        chk("rst_drop", 32'(bus.if_valid), 32'h0);
        step(0, 0, 1, 1, 2'b11, 32'h40, 32'h12345678, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        step(1, 32'h10, 0, 0, 2'b00, 0, 0, 0);
        chk("resume", 32'(bus.if_rdata), 32'h00500093);
        ip = 0; dp = 0; w = 0; ia = 0; da = 0; dd = 0;
        for (int i = 0; i < 300; i++) begin
            if (!ip) begin ip = 1'($urandom); ia = {22'h0, 8'($urandom), 2'b00}; end
            if (!dp) begin
                dp = 1'($urandom); w = 1'($urandom);
                da = {22'h0, 8'($urandom_range(0, 15)), 2'b00}; dd = $urandom;
            end
            step(ip, ia, dp, w, 2'b10, da, dd, 0);
            if (last_if) ip = 0;
            if (last_dm) dp = 0;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
